// File: rtl/sam_str_encoder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sam_str_encoder: serialises config (n, d, N) and message words onto SAM's mode/str lines.
// Optional phase jitter via SAM_STR_JITTER_EN.                             Rev 1.0
// -----------------------------------------------------------------------------
module sam_str_encoder #(
   parameter int KEY_W   = 8,
   parameter int MAX_N   = 15,
   parameter int T_LONG  = 20,
   parameter int T_SHORT = 8,
   parameter int T_GAP   = 4,
   parameter int T_STOP  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_start,
   input  logic [3:0]       cfg_n,
   input  logic [KEY_W-1:0] cfg_d,
   input  logic [KEY_W-1:0] cfg_N,
   output logic             cfg_ready,
   input  logic             msg_valid,
   input  logic [MAX_N-1:0] msg_data,
   output logic             msg_ready,
   output logic             configured,
   output logic             busy,
   output logic             mode,
   output logic             str
);

   localparam int         c_cfg_w = 4 + 2*KEY_W;
   localparam logic [3:0] c_max_n = 4'(MAX_N);

   typedef enum logic [2:0] {
      S_IDLE, S_CFG_LEAD, S_CFG_SHIFT, S_CFG_TRAIL, S_GAP, S_MSG_HI, S_MSG_LO, S_STOP
   } state_t;

   state_t             state_q, state_d;
   logic [c_cfg_w-1:0] cfg_sr_q, cfg_sr_d;
   logic [3:0]         n_q, n_d;
   logic [MAX_N-1:0]   msg_sr_q, msg_sr_d;
   logic [3:0]         bit_cnt_q, bit_cnt_d;
   logic [4:0]         phase_q, phase_d;
   logic [4:0]         lo_len_q, lo_len_d;
   logic               configured_q, configured_d;
   logic               mode_q, mode_d;
   logic               str_q, str_d;
   logic               start_bit;
   logic [4:0]         long_len, short_len;

`ifdef SAM_STR_JITTER_EN
   logic [7:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= 8'hA5;
      else       lfsr_q <= lfsr_d;
   end

   assign long_len  = 5'(T_LONG)  + {2'b00, lfsr_q[2:0]};
   assign short_len = 5'(T_SHORT) + {2'b00, lfsr_q[5:3]};
`else
   assign long_len  = 5'(T_LONG);
   assign short_len = 5'(T_SHORT);
`endif

   always_comb begin
      state_d      = state_q;
      cfg_sr_d     = cfg_sr_q;
      n_d          = n_q;
      msg_sr_d     = msg_sr_q;
      bit_cnt_d    = bit_cnt_q;
      phase_d      = phase_q;
      lo_len_d     = lo_len_q;
      configured_d = configured_q;
      start_bit    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cfg_start) begin
               cfg_sr_d = {cfg_n, cfg_d, cfg_N};
               n_d      = ({1'b0, cfg_n} > 5'(MAX_N)) ? c_max_n : cfg_n;
               state_d  = S_CFG_LEAD;
            end else if (msg_valid && configured_q) begin
               // Left-align so bit n-1 sits at the MSB and leaves first.
               msg_sr_d  = msg_data << (c_max_n - n_q);
               bit_cnt_d = n_q;
               if (n_q == 4'd0) begin
                  state_d = S_STOP;
                  phase_d = 5'(T_STOP - 1);
               end else begin
                  start_bit = 1'b1;
               end
            end
         end
         S_CFG_LEAD: begin
            state_d = S_CFG_SHIFT;
            phase_d = 5'(c_cfg_w - 1);
         end
         S_CFG_SHIFT: begin
            cfg_sr_d = cfg_sr_q << 1;
            if (phase_q == 5'd0) state_d = S_CFG_TRAIL;
            else                 phase_d = phase_q - 5'd1;
         end
         S_CFG_TRAIL: begin
            state_d      = S_GAP;
            phase_d      = 5'(T_GAP - 1);
            configured_d = 1'b1;
         end
         S_GAP: begin
            if (phase_q == 5'd0) state_d = S_IDLE;
            else                 phase_d = phase_q - 5'd1;
         end
         S_MSG_HI: begin
            if (phase_q == 5'd0) begin
               state_d = S_MSG_LO;
               phase_d = lo_len_q - 5'd1;
            end else begin
               phase_d = phase_q - 5'd1;
            end
         end
         S_MSG_LO: begin
            if (phase_q == 5'd0) begin
               msg_sr_d  = msg_sr_q << 1;
               bit_cnt_d = bit_cnt_q - 4'd1;
               if (bit_cnt_q == 4'd1) begin
                  state_d = S_STOP;
                  phase_d = 5'(T_STOP - 1);
               end else begin
                  start_bit = 1'b1;
               end
            end else begin
               phase_d = phase_q - 5'd1;
            end
         end
         S_STOP: begin
            if (phase_q == 5'd0) begin
               state_d = S_GAP;
               phase_d = 5'(T_GAP - 1);
            end else begin
               phase_d = phase_q - 5'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Durations are fixed for the whole bit at its first cycle.
      if (start_bit) begin
         state_d = S_MSG_HI;
         if (msg_sr_d[MAX_N-1]) begin
            phase_d  = long_len - 5'd1;
            lo_len_d = short_len;
         end else begin
            phase_d  = short_len - 5'd1;
            lo_len_d = long_len;
         end
      end

      mode_d = (state_d == S_CFG_LEAD) || (state_d == S_CFG_SHIFT) || (state_d == S_CFG_TRAIL);
      str_d  = (state_d == S_MSG_HI) || (state_d == S_STOP) ||
               ((state_d == S_CFG_SHIFT) && cfg_sr_d[c_cfg_w-1]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cfg_sr_q     <= '0;
         n_q          <= '0;
         msg_sr_q     <= '0;
         bit_cnt_q    <= '0;
         phase_q      <= '0;
         lo_len_q     <= '0;
         configured_q <= 1'b0;
         mode_q       <= 1'b0;
         str_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cfg_sr_q     <= cfg_sr_d;
         n_q          <= n_d;
         msg_sr_q     <= msg_sr_d;
         bit_cnt_q    <= bit_cnt_d;
         phase_q      <= phase_d;
         lo_len_q     <= lo_len_d;
         configured_q <= configured_d;
         mode_q       <= mode_d;
         str_q        <= str_d;
      end
   end

   assign cfg_ready  = (state_q == S_IDLE);
   assign msg_ready  = (state_q == S_IDLE) && configured_q;
   assign busy       = (state_q != S_IDLE);
   assign configured = configured_q;
   assign mode       = mode_q;
   assign str        = str_q;

endmodule
`default_nettype wire

// File: tb/tb_sam_str_encoder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_sam_str_encoder: scoreboard bench for sam_str_encoder (per-cycle line checks + decoder).
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_sam_str_encoder;

   localparam int T_LONG  = 20;
   localparam int T_SHORT = 8;
   localparam int T_GAP   = 4;
   localparam int T_STOP  = 2;
`ifdef SAM_STR_JITTER_EN
   localparam bit JIT = 1'b1;
`else
   localparam bit JIT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_start = 1'b0;
   logic [3:0]  cfg_n = '0;
   logic [7:0]  cfg_d = '0;
   logic [7:0]  cfg_N = '0;
   logic        msg_valid = 1'b0;
   logic [14:0] msg_data = '0;
   logic        cfg_ready, msg_ready, configured, busy, mode, str;

   sam_str_encoder dut (
      .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_n(cfg_n), .cfg_d(cfg_d),
      .cfg_N(cfg_N), .cfg_ready(cfg_ready), .msg_valid(msg_valid), .msg_data(msg_data),
      .msg_ready(msg_ready), .configured(configured), .busy(busy), .mode(mode), .str(str)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Per busy cycle: {mode, str, cfg_ready, msg_ready, configured}
   logic [4:0]  exp_q[$];
   // Per message: {n, data[n-1:0]}
   logic [18:0] dec_q[$];
   bit          tb_cfgd = 1'b0;
   logic [3:0]  tb_n = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_n(input logic [4:0] e, input int cnt);
      for (int i = 0; i < cnt; i++) exp_q.push_back(e);
   endtask

   task automatic push_cfg(input logic [3:0] n, input logic [7:0] d, input logic [7:0] nn);
      logic [19:0] b;
      b = {n, d, nn};
      push_n({4'b1000, tb_cfgd}, 1);
      for (int i = 19; i >= 0; i--) push_n({1'b1, b[i], 2'b00, tb_cfgd}, 1);
      push_n({4'b1000, tb_cfgd}, 1);
      if (!JIT) push_n(5'b00001, T_GAP);
      tb_cfgd = 1'b1;
      tb_n    = n;
   endtask

   task automatic push_msg(input logic [14:0] data);
      logic [14:0] m;
      m = 15'((32'd1 << tb_n) - 1);
      if (!JIT) begin
         for (int i = int'(tb_n) - 1; i >= 0; i--) begin
            push_n(5'b01001, data[i] ? T_LONG : T_SHORT);
            push_n(5'b00001, data[i] ? T_SHORT : T_LONG);
         end
         push_n(5'b01001, T_STOP);
         push_n(5'b00001, T_GAP);
      end
      dec_q.push_back({tb_n, data & m});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cfg(input logic [3:0] n, input logic [7:0] d, input logic [7:0] nn);
      int k;
      cfg_start = 1'b1; cfg_n = n; cfg_d = d; cfg_N = nn;
      for (k = 0; k < 5000 && !cfg_ready; k++) tick();
      if (!cfg_ready) chk("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
      push_cfg(n, d, nn);
      tick();
      cfg_start = 1'b0;
   endtask

   task automatic do_msg(input logic [14:0] data);
      int k;
      msg_valid = 1'b1; msg_data = data;
      for (k = 0; k < 5000 && !msg_ready; k++) tick();
      if (!msg_ready) chk("msg_ready_timeout", 32'(msg_ready), 32'd1);
      push_msg(data);
      tick();
      msg_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      for (k = 0; k < 5000 && busy; k++) tick();
      chk("idle_reached", 32'(busy), 32'd0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: per-cycle line check and a SAM-style decoder.
   int          run = 0;
   logic        prev = 1'b0;
   int          hi_save = 0;
   bit          have_hi = 1'b0;
   logic [14:0] word = '0;
   int          nb = 0;
   logic [4:0]  e;
   logic [18:0] de;

   always @(negedge clk) begin
      if (reset) begin
         run = 0; prev = 1'b0; have_hi = 1'b0; word = '0; nb = 0;
      end else begin
         if (busy && (!JIT || mode)) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_busy: got busy=1 with no expectation at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               chk("lines", 32'({mode, str, cfg_ready, msg_ready, configured}), 32'(e));
            end
         end
         if (mode) begin
            run = 0; prev = 1'b0; have_hi = 1'b0;
         end else if (str != prev) begin
            if (str) begin
               if (have_hi) begin
                  chk("hi_in_range", 32'(hi_save >= 5 && hi_save <= 29), 32'd1);
                  chk("lo_in_range", 32'(run >= 5 && run <= 29), 32'd1);
                  word = {word[13:0], (hi_save > run)};
                  nb++;
                  have_hi = 1'b0;
               end
            end else if (run >= 5) begin
               have_hi = 1'b1;
               hi_save = run;
            end else begin
               if (dec_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_stop: got stop pulse with no message at %0t", $time);
               end else begin
                  de = dec_q.pop_front();
                  chk("decoded", 32'({nb[3:0], word}), 32'(de));
               end
               word = '0; nb = 0;
            end
            run  = 1;
            prev = str;
         end else begin
            run++;
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset_state", 32'({mode, str, configured, busy, cfg_ready, msg_ready}), 32'b000010);

      msg_valid = 1'b1; msg_data = 15'h0005;
      repeat (3) tick();
      chk("msg_ignored_unconfigured", 32'(busy), 32'd0);
      msg_valid = 1'b0;

      do_cfg(4'd3, 8'hB4, 8'h5D);
      wait_idle();
      chk("configured_msg_ready", 32'({configured, msg_ready}), 32'b11);

      do_msg(15'b101);
      wait_idle();
      do_msg(15'b010);
      wait_idle();

      // Config and message requested together: config must go first.
      msg_valid = 1'b1; msg_data = 15'b110;
      do_cfg(4'd3, 8'h3C, 8'hC3);
      chk("cfg_priority", 32'({busy, mode, msg_ready}), 32'b110);
      do_msg(15'b110);
      wait_idle();

      // cfg_start while busy is dropped.
      do_msg(15'b111);
      repeat (10) tick();
      cfg_start = 1'b1; cfg_n = 4'd7; cfg_d = 8'hFF; cfg_N = 8'h00;
      tick();
      cfg_start = 1'b0;
      wait_idle();

      // Reset during the first MSG_HI.
      do_msg(15'b101);
      repeat (5) tick();
      reset = 1'b1;
      exp_q.delete(); dec_q.delete(); tb_cfgd = 1'b0;
      tick();
      reset = 1'b0;
      chk("mid_reset", 32'({mode, str, configured, msg_ready, busy}), 32'd0);
      msg_valid = 1'b1; msg_data = 15'b011;
      repeat (3) tick();
      chk("msg_ignored_after_reset", 32'(busy), 32'd0);
      msg_valid = 1'b0;
      do_cfg(4'd3, 8'hB4, 8'h5D);
      wait_idle();
      do_msg(15'b011);
      wait_idle();

      do_cfg(4'd0, 8'h12, 8'h34);
      wait_idle();
      do_msg(15'h1234);
      wait_idle();

      do_cfg(4'd15, 8'hA5, 8'h5A);
      wait_idle();
      do_msg(15'h7FFF);
      wait_idle();
      do_msg(15'h5A3C);
      wait_idle();

      if (JIT) begin
         do_cfg(4'd6, 8'h11, 8'h22);
         wait_idle();
         for (int i = 0; i < 200; i++) begin
            do_msg(15'($urandom));
            wait_idle();
         end
      end

      repeat (5) tick();
      chk("decoder_drained", 32'(dec_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
